// File: rtl/bullet_pool_pkg.sv
// Shared constants and types for the projectile pools: position packing,
// the dead-slot marker and default player/enemy tuning.
package bullet_pool_pkg;

    localparam int POS_X_W = 10;
    localparam int POS_Y_W = 9;
    localparam int POS_W   = POS_X_W + POS_Y_W;

    localparam logic [POS_W-1:0] DEAD_POSITION = 19'h7FFFF;

    localparam int PLAYER_SPEED    = 4;
    localparam int PLAYER_COOLDOWN = 11;
    localparam int ENEMY_SPEED     = 2;
    localparam int ENEMY_COOLDOWN  = 7;

    localparam logic [POS_Y_W-1:0] SCREEN_Y_MAX = 9'd479;

    typedef struct packed {
        logic [POS_X_W-1:0] x;
        logic [POS_Y_W-1:0] y;
    } pos_t;

    function automatic pos_t pack_pos(input logic [POS_X_W-1:0] x, input logic [POS_Y_W-1:0] y);
        pos_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

endpackage

// File: rtl/bullet_pool_first_free_slot.sv
// Lowest-index free slot finder: one-hot grant of the first clear bit of
// i_Busy, plus a flag when every slot is taken. Also used by the enemy shooter.
module first_free_slot #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_Busy,
    output logic [N-1:0] o_Grant,
    output logic         o_NoneFree
);

    logic [N-1:0] w_one;
    logic [N-1:0] w_busy_inc;

    assign w_one      = N'(1);
    // Adding one ripples through the low run of ones and lands on the first zero.
    assign w_busy_inc = i_Busy + w_one;
    assign o_Grant    = ~i_Busy & w_busy_inc;
    assign o_NoneFree = &i_Busy;

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool: spawn into the lowest free slot, per-tick vertical motion,
// despawn at the screen edge or on hit, and fire-rate limiting via a cooldown.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int         N_BULLETS      = 16,
    parameter int         COOLDOWN_TICKS = PLAYER_COOLDOWN,
    parameter int         CD_W           = 4,
    parameter int         SPEED          = PLAYER_SPEED,
    parameter bit         DIR            = 1'b0,
    parameter logic [8:0] Y_MAX          = 9'd479,
    parameter bit         FIRE_MODE      = 1'b0
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic                         i_Tick,
    input  logic                         i_Clear,
    input  logic                         i_Fire,
    input  logic [POS_X_W-1:0]           i_FireX,
    input  logic [POS_Y_W-1:0]           i_FireY,
    input  logic [N_BULLETS-1:0]         i_HitMask,
    output logic [N_BULLETS-1:0]         o_State,
    output logic [N_BULLETS*POS_W-1:0]   o_Position,
    output logic                         o_Fired,
    output logic                         o_Full
);

    localparam logic [POS_Y_W:0] SPEED_EXT = (POS_Y_W + 1)'(SPEED);
    localparam logic [POS_Y_W:0] Y_MAX_EXT = {1'b0, Y_MAX};
    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(COOLDOWN_TICKS);
    localparam logic [CD_W-1:0]  CD_ONE    = CD_W'(1);

    logic [N_BULLETS-1:0] r_state, w_state;
    pos_t [N_BULLETS-1:0] r_pos, w_pos;
    logic [CD_W-1:0]      r_cooldown, w_cooldown;
    logic                 r_pending, w_pending;
    logic                 r_fire_q, w_fire_q;
    logic                 r_fired, w_fired;

    logic [N_BULLETS-1:0] w_grant;
    logic                 w_none_free;
    logic                 w_edge;
    logic                 w_req;
    logic                 w_want;
    logic                 w_cd_zero;
    logic                 w_spawn;
    logic [POS_Y_W:0]     w_step;

    first_free_slot #(
        .N (N_BULLETS)
    ) u_first_free_slot (
        .i_Busy     (r_state),
        .o_Grant    (w_grant),
        .o_NoneFree (w_none_free)
    );

    // Returns {despawn, next_y}; the downward sum is one bit wider so it never wraps.
    function automatic logic [POS_Y_W:0] f_move(input logic [POS_Y_W-1:0] y);
        logic [POS_Y_W:0] sum_y;
        sum_y = {1'b0, y} + SPEED_EXT;
        if (DIR == 1'b0) begin
            if ({1'b0, y} < SPEED_EXT)
                f_move = {1'b1, y};
            else
                f_move = {1'b0, y - SPEED_EXT[POS_Y_W-1:0]};
        end else begin
            if (sum_y > Y_MAX_EXT)
                f_move = {1'b1, y};
            else
                f_move = {1'b0, sum_y[POS_Y_W-1:0]};
        end
    endfunction

    assign w_edge    = i_Fire & ~r_fire_q;
    assign w_req     = (FIRE_MODE == 1'b1) ? i_Fire : w_edge;
    assign w_want    = w_req | r_pending;
    assign w_cd_zero = (r_cooldown == '0);
    assign w_spawn   = w_want & w_cd_zero & ~w_none_free;

    always_comb begin
        w_state    = r_state;
        w_pos      = r_pos;
        w_cooldown = r_cooldown;
        w_pending  = r_pending;
        w_fire_q   = i_Fire;
        w_fired    = w_spawn;
        w_step     = '0;

        // Spawn decision sees the pre-tick cooldown; a reload beats the decrement.
        if (w_spawn)
            w_cooldown = CD_RELOAD;
        else if (i_Tick && !w_cd_zero)
            w_cooldown = r_cooldown - CD_ONE;

        if ((FIRE_MODE == 1'b0) && w_edge && !w_cd_zero)
            w_pending = 1'b1;
        if (w_want && w_cd_zero)
            w_pending = 1'b0;

        for (int k = 0; k < N_BULLETS; k++) begin
            if (r_state[k] && i_HitMask[k]) begin
                w_state[k] = 1'b0;
                w_pos[k]   = DEAD_POSITION;
            end else if (w_spawn && w_grant[k]) begin
                w_state[k] = 1'b1;
                w_pos[k]   = pack_pos(i_FireX, i_FireY);
            end else if (r_state[k] && i_Tick) begin
                w_step = f_move(r_pos[k].y);
                if (w_step[POS_Y_W]) begin
                    w_state[k] = 1'b0;
                    w_pos[k]   = DEAD_POSITION;
                end else begin
                    w_pos[k].y = w_step[POS_Y_W-1:0];
                end
            end
        end

        if (i_Clear) begin
            w_state    = '0;
            w_cooldown = '0;
            w_pending  = 1'b0;
            w_fire_q   = 1'b0;
            w_fired    = 1'b0;
            for (int k = 0; k < N_BULLETS; k++)
                w_pos[k] = DEAD_POSITION;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= '0;
            r_cooldown <= '0;
            r_pending  <= 1'b0;
            r_fire_q   <= 1'b0;
            r_fired    <= 1'b0;
            for (int k = 0; k < N_BULLETS; k++)
                r_pos[k] <= DEAD_POSITION;
        end else begin
            r_state    <= w_state;
            r_pos      <= w_pos;
            r_cooldown <= w_cooldown;
            r_pending  <= w_pending;
            r_fire_q   <= w_fire_q;
            r_fired    <= w_fired;
        end
    end

    assign o_State    = r_state;
    assign o_Position = r_pos;
    assign o_Fired    = r_fired;
    assign o_Full     = &r_state;

endmodule
